// File: rtl/vending_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vending_pkg
// Purpose  : Shared definitions for the vending machine blocks: the coin
//            dispenser state encoding, coin values and default widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vending_pkg;

    // Default width of payout amounts and shortfall
    localparam int DEF_CNT_W = 3;

    // Face value of each coin type, in coin units
    localparam int COIN1_VAL = 1;
    localparam int COIN2_VAL = 2;

    // Coin dispenser state encoding
    localparam int ST_W = 3;
    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SELECT  = 3'd1;
    localparam state_t ST_EJECT2  = 3'd2;
    localparam state_t ST_EJECT1  = 3'd3;
    localparam state_t ST_RELEASE = 3'd4;
    localparam state_t ST_DONE    = 3'd5;
    localparam state_t ST_FAULT   = 3'd6;

endpackage
`default_nettype wire

// File: rtl/coin_dispenser_if.sv
`default_nettype none
// ============================================================================
// Module   : coin_dispenser_if
// Purpose  : Signal bundle between the vending FSM / coin hopper and the
//            coin dispenser.
// Ports    : master - request side (req, amt, refill) and hopper ack; sees
//                     hopper commands, status and inventory.
//            slave  - the dispenser itself.
// Revision : 1.0 - initial release
// ============================================================================
interface coin_dispenser_if
    import vending_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int INV_W = 6
) ();

    logic             req;
    logic [CNT_W-1:0] amt;
    logic             refill;
    logic             hop_ack;
    logic             hop_c1;
    logic             hop_c2;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] short;
    logic             fault;
    logic [INV_W-1:0] inv1;
    logic [INV_W-1:0] inv2;

    modport master (
        output req, amt, refill, hop_ack,
        input  hop_c1, hop_c2, busy, done, short, fault, inv1, inv2
    );

    modport slave (
        input  req, amt, refill, hop_ack,
        output hop_c1, hop_c2, busy, done, short, fault, inv1, inv2
    );

endinterface
`default_nettype wire

// File: rtl/hopper_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : hopper_watchdog
// Purpose  : Saturating timeout counter. Cleared by clr_i, advanced by en_i;
//            trip_o is high while the count equals TIMEOUT (TIMEOUT >= 1).
// Ports    : clk, rst (sync, active-low), clr_i, en_i, trip_o
// Revision : 1.0 - initial release
// ============================================================================
module hopper_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic trip_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    assign trip_o = (cnt_q == CW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !trip_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/coin_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : coin_dispenser
// Purpose  : Pays out a change/refund amount through a two-chute hopper,
//            2-unit coins first, one eject at a time with ack handshake.
//            Tracks per-chute inventory and reports the unpaid shortfall.
//            Optional hopper watchdog: COIN_DISPENSER_WATCHDOG_EN.
// Ports    : clk, rst (sync, active-low), bus (coin_dispenser_if.slave)
// Revision : 1.0 - initial release
// ============================================================================
module coin_dispenser
    import vending_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int INV_W       = 6,
    parameter int INV1_INIT   = 16,
    parameter int INV2_INIT   = 16,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    coin_dispenser_if.slave      bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] short_q, short_d;
    logic [INV_W-1:0] inv1_q, inv1_d;
    logic [INV_W-1:0] inv2_q, inv2_d;
    logic             hop_c1_q, hop_c1_d;
    logic             hop_c2_q, hop_c2_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;

    logic             w_in_eject;
    logic             w_trip;

    assign w_in_eject = (state_q == ST_EJECT2) || (state_q == ST_EJECT1);

`ifdef COIN_DISPENSER_WATCHDOG_EN
    // Counter is held clear outside EJECT, so it restarts on every entry
    hopper_watchdog #(
        .TIMEOUT (ACK_TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (!w_in_eject),
        .en_i   (w_in_eject && !bus.hop_ack),
        .trip_o (w_trip)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (ACK_TIMEOUT != 0);
    assign w_trip           = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            short_q  <= '0;
            inv1_q   <= INV_W'(INV1_INIT);
            inv2_q   <= INV_W'(INV2_INIT);
            hop_c1_q <= 1'b0;
            hop_c2_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            short_q  <= short_d;
            inv1_q   <= inv1_d;
            inv2_q   <= inv2_d;
            hop_c1_q <= hop_c1_d;
            hop_c2_q <= hop_c2_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state and transition actions
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        short_d = short_q;
        inv1_d  = inv1_q;
        inv2_d  = inv2_q;
        case (state_q)
            ST_IDLE: begin
                // Refill lands in the same edge as req, so SELECT sees it
                if (bus.refill) begin
                    inv1_d = INV_W'(INV1_INIT);
                    inv2_d = INV_W'(INV2_INIT);
                end
                if (bus.req) begin
                    rem_d   = bus.amt;
                    short_d = '0;
                    state_d = (bus.amt != '0) ? ST_SELECT : ST_DONE;
                end
            end
            ST_SELECT: begin
                if (rem_q >= CNT_W'(COIN2_VAL) && inv2_q != '0) begin
                    state_d = ST_EJECT2;
                end else if (rem_q != '0 && inv1_q != '0) begin
                    state_d = ST_EJECT1;
                end else begin
                    // rem of zero here means fully paid, shortfall 0
                    short_d = rem_q;
                    state_d = ST_DONE;
                end
            end
            ST_EJECT2: begin
                if (bus.hop_ack) begin
                    inv2_d  = inv2_q - INV_W'(1);
                    rem_d   = rem_q - CNT_W'(COIN2_VAL);
                    state_d = ST_RELEASE;
                end else if (w_trip) begin
                    short_d = rem_q;
                    state_d = ST_FAULT;
                end
            end
            ST_EJECT1: begin
                if (bus.hop_ack) begin
                    inv1_d  = inv1_q - INV_W'(1);
                    rem_d   = rem_q - CNT_W'(COIN1_VAL);
                    state_d = ST_RELEASE;
                end else if (w_trip) begin
                    short_d = rem_q;
                    state_d = ST_FAULT;
                end
            end
            ST_RELEASE: begin
                if (!bus.hop_ack) begin
                    state_d = ST_SELECT;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode, registered one cycle behind the state
    always_comb begin
        busy_d   = (state_q == ST_SELECT) || w_in_eject || (state_q == ST_RELEASE);
        // Drop the eject command on the same edge that samples the ack
        hop_c2_d = (state_q == ST_EJECT2) && !bus.hop_ack;
        hop_c1_d = (state_q == ST_EJECT1) && !bus.hop_ack;
        done_d   = (state_q == ST_DONE);
`ifdef COIN_DISPENSER_WATCHDOG_EN
        fault_d  = (state_q == ST_FAULT);
`else
        fault_d  = 1'b0;
`endif
    end

    assign bus.hop_c1 = hop_c1_q;
    assign bus.hop_c2 = hop_c2_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.short  = short_q;
    assign bus.fault  = fault_q;
    assign bus.inv1   = inv1_q;
    assign bus.inv2   = inv2_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_dispenser
// Purpose  : Directed self-checking bench for coin_dispenser. Acts as vending
//            FSM and as a reactive hopper that acks each eject command.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_coin_dispenser;

    logic clk = 1'b0;
    logic rst;
    int   n_vec   = 0;
    int   n_err   = 0;
    int   both_hi = 0;

    coin_dispenser_if #(.CNT_W(3), .INV_W(6)) bus ();

    coin_dispenser #(
        .CNT_W       (3),
        .INV_W       (6),
        .INV1_INIT   (16),
        .INV2_INIT   (16),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic issue_req(input int a);
        bus.amt = 3'(a);
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
    endtask

    // Hopper model: ack each eject after dly cycles, count coins until done.
    // cyc counts edges from the request edge to done becoming visible.
    task automatic serve(input int dly, output int n1, output int n2, output int cyc);
        n1  = 0;
        n2  = 0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 200) begin
            if (bus.hop_c1 === 1'b1 || bus.hop_c2 === 1'b1) begin
                if (bus.hop_c1 === 1'b1 && bus.hop_c2 === 1'b1) both_hi++;
                if (bus.hop_c1 === 1'b1) n1++;
                else n2++;
                for (int k = 0; k < dly; k++) begin
                    tick();
                    cyc++;
                end
                bus.hop_ack = 1'b1;
                tick();
                cyc++;
                bus.hop_ack = 1'b0;
            end else begin
                tick();
                cyc++;
            end
        end
        chk("done_seen", bus.done, 1);
    endtask

    task automatic pay(input string tag, input int a, input int dly,
                       input int e1, input int e2, input int eshort);
        int n1, n2, cyc;
        issue_req(a);
        serve(dly, n1, n2, cyc);
        chk({tag, "_n1"}, n1, e1);
        chk({tag, "_n2"}, n2, e2);
        chk({tag, "_short"}, bus.short, eshort);
    endtask

    initial begin
        int n1, n2, cyc, dcount;

        rst         = 1'b0;
        bus.req     = 1'b0;
        bus.amt     = '0;
        bus.refill  = 1'b0;
        bus.hop_ack = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_hop_c1", bus.hop_c1, 0);
        chk("rst_hop_c2", bus.hop_c2, 0);
        chk("rst_busy",   bus.busy,   0);
        chk("rst_done",   bus.done,   0);
        chk("rst_fault",  bus.fault,  0);
        chk("rst_short",  bus.short,  0);
        chk("rst_inv1",   bus.inv1,   16);
        chk("rst_inv2",   bus.inv2,   16);
        rst = 1'b1;
        tick();

        // Full payout of 5 with request-to-eject latency
        issue_req(5);
        chk("lat_busy_n0", bus.busy, 0);
        tick();
        chk("lat_busy_n1", bus.busy, 1);
        chk("lat_hop_n1", bus.hop_c2, 0);
        tick();
        chk("lat_hop_c2_n2", bus.hop_c2, 1);
        chk("lat_hop_c1_n2", bus.hop_c1, 0);
        serve(2, n1, n2, cyc);
        chk("full_n2", n2, 2);
        chk("full_n1", n1, 1);
        chk("full_short", bus.short, 0);
        chk("full_inv2", bus.inv2, 14);
        chk("full_inv1", bus.inv1, 15);
        chk("full_busy_end", bus.busy, 0);
        tick();
        chk("done_pulse_1cyc", bus.done, 0);

        // Drain the 2-unit chute: 3+3+3+3+2 coins
        for (int i = 0; i < 4; i++) pay("drain2", 6, 0, 0, 3, 0);
        pay("drain2_last", 4, 0, 0, 2, 0);
        chk("drain2_inv2", bus.inv2, 0);

        // No 2-unit coins: amount 3 paid with three 1-unit coins
        pay("only1", 3, 1, 3, 0, 0);
        chk("only1_inv1", bus.inv1, 12);

        // Drain the 1-unit chute down to one coin, then partial payout
        pay("drain1a", 7, 0, 7, 0, 0);
        pay("drain1b", 4, 0, 4, 0, 0);
        chk("drain1_inv1", bus.inv1, 1);
        pay("partial", 3, 0, 1, 0, 2);
        chk("partial_inv1", bus.inv1, 0);

        // Both chutes empty: shortfall, done two edges after request
        issue_req(4);
        serve(0, n1, n2, cyc);
        chk("short_n", n1 + n2, 0);
        chk("short_lat", cyc, 2);
        chk("short_val", bus.short, 4);

        // Refill, then pay 4 with two 2-unit coins
        bus.refill = 1'b1;
        tick();
        bus.refill = 1'b0;
        chk("refill_inv1", bus.inv1, 16);
        chk("refill_inv2", bus.inv2, 16);
        pay("after_refill", 4, 1, 0, 2, 0);
        chk("after_refill_inv2", bus.inv2, 14);

        // req and refill while busy are ignored
        issue_req(2);
        tick();
        chk("blk_busy", bus.busy, 1);
        bus.amt    = 3'd7;
        bus.req    = 1'b1;
        bus.refill = 1'b1;
        tick();
        bus.req    = 1'b0;
        bus.refill = 1'b0;
        serve(0, n1, n2, cyc);
        chk("blk_n2", n2, 1);
        chk("blk_n1", n1, 0);
        repeat (4) tick();
        chk("blk_no_queue", bus.busy, 0);
        chk("blk_inv2", bus.inv2, 13);
        chk("blk_inv1", bus.inv1, 16);

        // Zero amount: done one edge after acceptance, no ejects
        issue_req(0);
        serve(0, n1, n2, cyc);
        chk("zero_n", n1 + n2, 0);
        chk("zero_lat", cyc, 1);
        chk("zero_short", bus.short, 0);

        // Hopper never acks
        issue_req(2);
`ifdef COIN_DISPENSER_WATCHDOG_EN
        cyc = 0;
        while (bus.fault !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("wd_fault", bus.fault, 1);
        chk("wd_latency", cyc, 18);
        chk("wd_short", bus.short, 2);
        chk("wd_inv2", bus.inv2, 13);
        chk("wd_hop_c2", bus.hop_c2, 0);
        chk("wd_busy", bus.busy, 0);
        bus.refill = 1'b1;
        issue_req(1);
        bus.refill = 1'b0;
        repeat (3) tick();
        chk("wd_ign_busy", bus.busy, 0);
        chk("wd_ign_hop_c1", bus.hop_c1, 0);
        chk("wd_ign_fault", bus.fault, 1);
        chk("wd_ign_inv2", bus.inv2, 13);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("wd_rst_fault", bus.fault, 0);
        issue_req(5);
        tick();
        tick();
        chk("mid_hop_c2", bus.hop_c2, 1);
`else
        repeat (40) tick();
        chk("nowd_hop_c2", bus.hop_c2, 1);
        chk("nowd_fault", bus.fault, 0);
        chk("nowd_busy", bus.busy, 1);
        chk("nowd_inv2", bus.inv2, 13);
`endif

        // Reset in the middle of an eject
        rst = 1'b0;
        tick();
        chk("mid_rst_hop_c1", bus.hop_c1, 0);
        chk("mid_rst_hop_c2", bus.hop_c2, 0);
        chk("mid_rst_busy",   bus.busy,   0);
        chk("mid_rst_done",   bus.done,   0);
        chk("mid_rst_fault",  bus.fault,  0);
        chk("mid_rst_short",  bus.short,  0);
        chk("mid_rst_inv1",   bus.inv1,   16);
        chk("mid_rst_inv2",   bus.inv2,   16);
        rst = 1'b1;
        dcount = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.done === 1'b1) dcount++;
        end
        chk("mid_rst_no_done", dcount, 0);
        chk("c1_c2_exclusive", both_hi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/coin_dispenser.md
# coin_dispenser

Change and refund payout unit for the vending machine. Accepts a coin-unit amount from the vending FSM (the `cng` value after a sale, or the `rtn` value after a cancel) and pays it out through a two-chute coin hopper. It issues one eject command at a time, paying 2-unit coins first, and waits for a hopper acknowledge before each next coin. It tracks coin inventory per chute and reports any amount it could not pay.

## Interface
- `CNT_W`, 3, width of the amount and shortfall.
- `INV_W`, 6, width of each inventory counter.
- `INV1_INIT`, 16, 1-unit coin count loaded at reset and on refill.
- `INV2_INIT`, 16, 2-unit coin count loaded at reset and on refill.
- `ACK_TIMEOUT`, 15, cycles in an eject state without `hop_ack` before fault. Used only with the watchdog compiled in.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: reset, synchronous, active-low.
- `req` in 1: 1-cycle payout request.
- `amt` in CNT_W: amount to pay. Sampled with `req`.
- `refill` in 1: 1-cycle reload of both inventories to their INIT values.
- `hop_ack` in 1: hopper has released the coin. Level signal, must return low between coins.
- `hop_c1` out 1: eject one 1-unit coin. Held until ack.
- `hop_c2` out 1: eject one 2-unit coin. Held until ack.
- `busy` out 1: payout in progress.
- `done` out 1: 1-cycle pulse when a payout ends.
- `short` out CNT_W: unpaid remainder. Valid with `done`, and held until the next accepted `req`.
- `fault` out 1: hopper watchdog tripped. Sticky.
- `inv1` out INV_W: current 1-unit coin inventory.
- `inv2` out INV_W: current 2-unit coin inventory.

## Operation
States: IDLE, SELECT, EJECT2, EJECT1, RELEASE, DONE, FAULT. All outputs are registered.

- **Reset** (`rst`=0 at a clock edge):
  - State goes to IDLE.
  - `hop_c1`, `hop_c2`, `busy`, `done`, `fault` = 0; `short` = 0.
  - `inv1` = INV1_INIT, `inv2` = INV2_INIT.
  - `rem` (internal remaining amount) = 0.
  - Reset mid-payout aborts it immediately, with no `done` pulse.
- **IDLE**:
  - `req` with `amt`≠0: latch `rem`=`amt`, clear `short`, go to SELECT.
  - `req` with `amt`=0: go to DONE with `short`=0.
  - `refill` reloads both inventories.
  - If `req` and `refill` arrive in the same cycle, both take effect; SELECT then sees the refilled inventory.
- **Outside IDLE**: `req` and `refill` are ignored. There is no queueing.
- **SELECT**, first matching rule wins:
  - `rem`≥2 and `inv2`>0: go to EJECT2.
  - `rem`≥1 and `inv1`>0: go to EJECT1.
  - `rem`=0: go to DONE with `short`=0.
  - Otherwise: go to DONE with `short`=`rem`.
  - Example: `rem`=3 with `inv2`=0 and `inv1`=1 pays one 1-unit coin, then ends with `short`=2.
- **EJECTx**:
  - `hop_cx`=1.
  - When `hop_ack` is sampled high: `hop_cx`=0, decrement `invx` by 1, decrement `rem` by the coin value, go to RELEASE.
  - `hop_c1` and `hop_c2` are never high together.
- **RELEASE**: wait for `hop_ack`=0, then go to SELECT.
- **DONE**: `done`=1 for one cycle, `busy`=0, return to IDLE.
- **FAULT**:
  - Both hop outputs 0, `fault`=1, `busy`=0.
  - `short` = `rem` at the time of the trip. Inventory is not decremented for the unacknowledged coin.
  - Exit only by reset. `req` and `refill` are ignored.
- **Arithmetic**: inventories never underflow because SELECT guards each eject. `rem` is unsigned CNT_W.

## Timing
- `req` sampled at edge N:
  - `busy`=1 after edge N+1.
  - `hop_cx`=1 after edge N+2.
- Per coin, minimum 3 cycles: EJECT with ack present, RELEASE with ack already low, SELECT.
- `done` pulse follows SELECT by one edge.
- Zero-amount request: `done` one edge after acceptance, with no hop activity.
- `hop_ack` high already on entry to EJECT is accepted on that first EJECT cycle.
- Watchdog counter:
  - Clears on entry to each EJECT state and counts each EJECT cycle without ack.
  - When the count reaches ACK_TIMEOUT, the next edge enters FAULT.
  - An ack arriving on the same cycle as the timeout wins.

## Configuration
- `COIN_DISPENSER_WATCHDOG_EN` defined: watchdog and FAULT state present, as described above.
- Not defined:
  - EJECT waits indefinitely for `hop_ack`.
  - FAULT is unreachable and `fault` is tied to 0.
  - `ACK_TIMEOUT` is unused.

## Structure
- Shared package `vending_pkg` holds:
  - the state encoding constants;
  - coin value constants `COIN1_VAL`=1 and `COIN2_VAL`=2;
  - default CNT_W.
- Sub-module `hopper_watchdog`: clear/enable timeout counter with a `trip` output. Instantiated only when the watchdog macro is defined.

## Test plan
- **Full payout:** reset, `req` `amt`=5, hopper acks after 2 cycles.
  - Expect `hop_c2`, `hop_c2`, `hop_c1`.
  - Expect `done` with `short`=0, `inv2`=14, `inv1`=15.
- **Out of 2-unit coins:** `inv2` drained to 0, then `req` `amt`=3.
  - Expect three `hop_c1` ejects and `short`=0.
- **Shortfall:** both inventories empty, `req` `amt`=4.
  - Expect no hop pulses, `done` 2 cycles after `req`, `short`=4.
  - Then `refill` followed by `req` `amt`=4: expect two `hop_c2` ejects and `short`=0.
- **Watchdog:** `req` `amt`=2 with `hop_ack` held 0.
  - Expect `fault`=1 after 15 EJECT cycles, `short`=2, `inv2` unchanged.
  - `req` is ignored until reset.
- **Blocking and reset:** `req` during `busy` is ignored. `amt`=0 gives `done` with no eject. Reset asserted mid-EJECT gives all outputs at reset values the next cycle.
